serial_sub: RTL

- Bit-serial unsigned subtractor with a borrow chain; the inverse operation of the 4-bit ripple full adder.
- Computes diff = a - b - b_in, one bit per clock, LSB first.
- Uses a start/busy/done handshake.
- Used wherever a small, area-cheap subtract is needed and multi-cycle latency is acceptable.

---
 rtl/serial_sub_if.sv | 23 ++
 rtl/serial_sub.sv | 99 +++++++++
 2 files changed

// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_sub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;

    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, b_out
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, b_out
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// A request is accepted in IDLE or DONE, shifted for WIDTH edges, then the
// result and borrow-out are published together with a one-cycle done pulse.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] diff_q;
    logic             b_out_q;
    logic             res_bit;
    logic             borrow_nxt;
    logic             last;
    logic             accept;

    function automatic logic sub_bit(input logic ai, input logic bi, input logic bri);
        return ai ^ bi ^ bri;
    endfunction

    function automatic logic sub_borrow(input logic ai, input logic bi, input logic bri);
        return (~ai & bi) | (~ai & bri) | (bi & bri);
    endfunction

    assign res_bit    = sub_bit(a_sr[0], b_sr[0], br);
    assign borrow_nxt = sub_borrow(a_sr[0], b_sr[0], br);
    assign last       = (cnt == CNT_W'(WIDTH - 1));
    // A new request may be taken whenever no operation is shifting, including DONE.
    assign accept     = bus.start && (state != SHIFT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state alone.
    always_comb begin
        bus.busy = (state == SHIFT);
        bus.done = (state == DONE);
    end

    // Serial datapath; the minuend register doubles as the result register,
    // taking each result bit into its MSB as the operand bits leave at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
        end else if (accept) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            br   <= bus.b_in;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= {res_bit, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            br   <= borrow_nxt;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                diff_q  <= {res_bit, a_sr[WIDTH-1:1]};
                b_out_q <= borrow_nxt;
            end
        end
    end

    assign bus.diff  = diff_q;
    assign bus.b_out = b_out_q;

endmodule
